// File: rtl/lsu_input_bank_dbnc.sv
// Memory-mapped switch/button input bank: 2-flop sync, per-bit debounce, W1C rising-edge
// status with level interrupt, and registered RV32I loads with one cycle of latency.
module lsu_input_bank_dbnc #(
  parameter int NUM_SW       = 32,
  parameter int NUM_BTN      = 4,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [4:0]         i_lsu_addr,
  input  logic               i_rd_en,
  input  logic               i_wr_en,
  input  logic [31:0]        i_wdata,
  input  logic [2:0]         i_funct3,
  input  logic [NUM_SW-1:0]  i_sw,
  input  logic [NUM_BTN-1:0] i_btn,
  output logic [31:0]        o_rdata,
  output logic               o_rvalid,
  output logic               o_irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [NUM_SW-1:0]  sw_meta, sw_sync, sw_stable;
  logic [NUM_BTN-1:0] btn_meta, btn_sync, btn_stable;
  logic [CNT_W-1:0]   sw_cnt  [NUM_SW];
  logic [CNT_W-1:0]   btn_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] btn_accept, btn_rise, btn_stat, irq_en, clr_bits;
  logic               lane0_we, stat_wr, en_wr;
  logic [31:0]        word;
  logic               unused_wdata;

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] off,
                                              input logic [2:0] f3);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd4:    return {24'b0, sh[7:0]};
      3'd1:    return off[0] ? 32'b0 : {{16{sh[15]}}, sh[15:0]};
      3'd5:    return off[0] ? 32'b0 : {16'b0, sh[15:0]};
      3'd2:    return (off == 2'b00) ? w : 32'b0;
      default: return 32'b0;
    endcase
  endfunction

  // A button rises on the very edge its debounced level flips to 1.
  always_comb begin
    btn_accept = '0;
    for (int i = 0; i < NUM_BTN; i++)
      btn_accept[i] = (btn_sync[i] != btn_stable[i]) && (btn_cnt[i] == CNT_LAST);
  end
  assign btn_rise = btn_accept & btn_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sw_meta    <= '0;
      sw_sync    <= '0;
      sw_stable  <= '0;
      btn_meta   <= '0;
      btn_sync   <= '0;
      btn_stable <= '0;
      for (int i = 0; i < NUM_SW; i++)  sw_cnt[i]  <= '0;
      for (int i = 0; i < NUM_BTN; i++) btn_cnt[i] <= '0;
    end else begin
      sw_meta  <= i_sw;
      sw_sync  <= sw_meta;
      btn_meta <= i_btn;
      btn_sync <= btn_meta;
      for (int i = 0; i < NUM_SW; i++) begin
        if (sw_sync[i] == sw_stable[i]) sw_cnt[i] <= '0;
        else if (sw_cnt[i] == CNT_LAST) begin
          sw_stable[i] <= sw_sync[i];
          sw_cnt[i]    <= '0;
        end else sw_cnt[i] <= sw_cnt[i] + 1'b1;
      end
      for (int i = 0; i < NUM_BTN; i++) begin
        if (btn_sync[i] == btn_stable[i]) btn_cnt[i] <= '0;
        else if (btn_cnt[i] == CNT_LAST) begin
          btn_stable[i] <= btn_sync[i];
          btn_cnt[i]    <= '0;
        end else btn_cnt[i] <= btn_cnt[i] + 1'b1;
      end
    end
  end

  // All writable bits live in lane 0, so only stores that cover byte 0 can change state.
  assign lane0_we     = i_wr_en && (i_lsu_addr[1:0] == 2'b00) &&
                        (i_funct3 inside {3'd0, 3'd1, 3'd2});
  assign stat_wr      = lane0_we && (i_lsu_addr[4:2] == 3'd5);
  assign en_wr        = lane0_we && (i_lsu_addr[4:2] == 3'd6);
  assign clr_bits     = stat_wr ? i_wdata[NUM_BTN-1:0] : '0;
  assign unused_wdata = &{1'b0, i_wdata[31:NUM_BTN]};

  always_comb begin
    case (i_lsu_addr[4:2])
      3'd0:    word = 32'(sw_stable);
      3'd4:    word = 32'(btn_stable);
      3'd5:    word = 32'(btn_stat);
      3'd6:    word = 32'(irq_en);
      default: word = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      btn_stat <= '0;
      irq_en   <= '0;
      o_irq    <= 1'b0;
      o_rvalid <= 1'b0;
      o_rdata  <= '0;
    end else begin
      btn_stat <= (btn_stat & ~clr_bits) | btn_rise;
      if (en_wr) irq_en <= i_wdata[NUM_BTN-1:0];
      o_irq    <= |(btn_stat & irq_en);
      o_rvalid <= i_rd_en;
      o_rdata  <= i_rd_en ? load_extend(word, i_lsu_addr[1:0], i_funct3) : '0;
    end
  end

endmodule

// File: tb/tb_lsu_input_bank_dbnc.sv
// Randomized and directed bench for lsu_input_bank_dbnc against an in-bench behavioural model.
module tb_lsu_input_bank_dbnc;
  localparam int NSW = 32;
  localparam int NBTN = 4;
  localparam int DB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] addr = '0;
  logic rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] wdata = '0;
  logic [2:0] funct3 = '0;
  logic [NSW-1:0] sw = '0;
  logic [NBTN-1:0] btn = '0;
  logic [31:0] rdata;
  logic rvalid, irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_input_bank_dbnc #(.NUM_SW(NSW), .NUM_BTN(NBTN), .DEBOUNCE_CYC(DB)) dut (
    .i_clk(clk), .i_rst(rst), .i_lsu_addr(addr), .i_rd_en(rd_en), .i_wr_en(wr_en),
    .i_wdata(wdata), .i_funct3(funct3), .i_sw(sw), .i_btn(btn),
    .o_rdata(rdata), .o_rvalid(rvalid), .o_irq(irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: raw inputs seen two clocks late; a level is accepted after DB
  // consecutive differing samples.
  logic [NSW-1:0]  m_sw_d1 = '0, m_sw_d2 = '0, m_sw_st = '0;
  logic [NBTN-1:0] m_bt_d1 = '0, m_bt_d2 = '0, m_bt_st = '0, m_stat = '0, m_en = '0;
  int m_swrun[NSW];
  int m_btrun[NBTN];
  logic [31:0] e_rdata = '0;
  logic e_rvalid = 1'b0, e_irq = 1'b0;

  function automatic logic [31:0] m_load(input logic [4:0] a, input logic [2:0] f);
    logic [31:0] w;
    logic [7:0] by[4];
    logic signed [31:0] s;
    int o;
    case (a[4:2])
      3'd0: w = m_sw_st;
      3'd4: w = {28'b0, m_bt_st};
      3'd5: w = {28'b0, m_stat};
      3'd6: w = {28'b0, m_en};
      default: w = 0;
    endcase
    for (int k = 0; k < 4; k++) by[k] = w[8*k +: 8];
    o = int'(a[1:0]);
    case (f)
      3'd0: begin s = $signed(by[o]); return s; end
      3'd4: return {24'b0, by[o]};
      3'd1: begin
        if (o % 2 != 0) return 0;
        s = $signed({by[o+1], by[o]});
        return s;
      end
      3'd5: return (o % 2 != 0) ? 0 : {16'b0, by[o+1], by[o]};
      3'd2: return (o != 0) ? 0 : w;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [NBTN-1:0] old_bt, clr;
    if (rst) begin
      m_sw_d1 = '0; m_sw_d2 = '0; m_sw_st = '0;
      m_bt_d1 = '0; m_bt_d2 = '0; m_bt_st = '0; m_stat = '0; m_en = '0;
      for (int b = 0; b < NSW; b++) m_swrun[b] = 0;
      for (int b = 0; b < NBTN; b++) m_btrun[b] = 0;
      e_rdata = '0; e_rvalid = 1'b0; e_irq = 1'b0;
    end else begin
      e_irq = |(m_stat & m_en);
      e_rvalid = rd_en;
      e_rdata = rd_en ? m_load(addr, funct3) : 32'b0;
      old_bt = m_bt_st;
      for (int b = 0; b < NSW; b++) begin
        if (m_sw_d2[b] != m_sw_st[b]) begin
          m_swrun[b]++;
          if (m_swrun[b] == DB) begin m_sw_st[b] = m_sw_d2[b]; m_swrun[b] = 0; end
        end else m_swrun[b] = 0;
      end
      for (int b = 0; b < NBTN; b++) begin
        if (m_bt_d2[b] != m_bt_st[b]) begin
          m_btrun[b]++;
          if (m_btrun[b] == DB) begin m_bt_st[b] = m_bt_d2[b]; m_btrun[b] = 0; end
        end else m_btrun[b] = 0;
      end
      m_sw_d2 = m_sw_d1; m_sw_d1 = sw;
      m_bt_d2 = m_bt_d1; m_bt_d1 = btn;
      clr = '0;
      if (wr_en && addr[1:0] == 2'b00 && funct3 <= 3'd2) begin
        if (addr[4:2] == 3'd5) clr = wdata[NBTN-1:0];
        if (addr[4:2] == 3'd6) m_en = wdata[NBTN-1:0];
      end
      m_stat = (m_stat & ~clr) | (m_bt_st & ~old_bt);
    end
  end

  always @(negedge clk) begin : compare
    #1;
    if (rst) begin
      chk("rvalid_rst", rvalid, 0);
      chk("rdata_rst", rdata, 0);
      chk("irq_rst", irq, 0);
    end else begin
      chk("rvalid", rvalid, e_rvalid);
      chk("rdata", rdata, e_rdata);
      chk("irq", irq, e_irq);
    end
  end

  task automatic do_load(input logic [4:0] a, input logic [2:0] f, output logic [31:0] d);
    addr = a; funct3 = f; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    #1 d = rdata;
  endtask

  task automatic do_store(input logic [4:0] a, input logic [2:0] f, input logic [31:0] w);
    addr = a; funct3 = f; wdata = w; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [NSW-1:0] sw_base;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rvalid", rvalid, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_irq", irq, 0);
    @(negedge clk);
    rst = 1'b0;

    // Debounce latency and glitch rejection
    sw = 32'hA5A5_0F0F;
    repeat (DB + 1) @(negedge clk);
    do_load(5'h00, 3'd2, d); chk("t2_before", d, 32'h0);
    do_load(5'h00, 3'd2, d); chk("t2_after", d, 32'hA5A5_0F0F);
    sw = 32'hA5A5_0F0E;
    @(negedge clk);
    sw = 32'hA5A5_0F0F;
    repeat (25) @(negedge clk);
    do_load(5'h00, 3'd2, d); chk("t2_glitch", d, 32'hA5A5_0F0F);

    // Load extension
    sw = 32'h8081_82F3;
    repeat (DB + 4) @(negedge clk);
    do_load(5'h00, 3'd0, d); chk("t3_lb", d, 32'hFFFF_FFF3);
    do_load(5'h01, 3'd4, d); chk("t3_lbu", d, 32'h0000_0082);
    do_load(5'h02, 3'd1, d); chk("t3_lh", d, 32'hFFFF_8081);
    do_load(5'h01, 3'd5, d); chk("t3_lhu_mis", d, 32'h0);
    do_load(5'h02, 3'd2, d); chk("t3_lw_mis", d, 32'h0);
    do_load(5'h1C, 3'd2, d); chk("t3_unused", d, 32'h0);

    // Edge, W1C and interrupt
    do_store(5'h18, 3'd2, 32'h1);
    btn = 4'h1;
    repeat (DB + 4) @(negedge clk);
    #1 chk("t4_irq_set", irq, 1);
    do_load(5'h14, 3'd2, d); chk("t4_stat_set", d, 32'h1);
    do_load(5'h10, 3'd2, d); chk("t4_btn_val", d, 32'h1);
    do_store(5'h14, 3'd2, 32'h1);
    @(negedge clk);
    #1 chk("t4_irq_clr", irq, 0);
    do_load(5'h14, 3'd2, d); chk("t4_stat_clr", d, 32'h0);
    btn = 4'h0;
    repeat (DB + 4) @(negedge clk);
    do_load(5'h14, 3'd2, d); chk("t4_release", d, 32'h0);
    do_store(5'h16, 3'd1, 32'hFFFF_FFFF);
    do_load(5'h18, 3'd2, d); chk("t4_en_lane", d, 32'h1);

    // Set wins over a same-cycle W1C
    btn = 4'h2;
    repeat (DB + 1) @(negedge clk);
    do_store(5'h14, 3'd2, 32'h2);
    do_load(5'h14, 3'd2, d); chk("t5_collision", d, 32'h2);
    do_store(5'h14, 3'd0, 32'hF);

    // Back-to-back loads
    addr = 5'h00; funct3 = 3'd2; rd_en = 1'b1;
    @(negedge clk);
    #1 chk("t6_v0", rvalid, 1);
    chk("t6_d0", rdata, 32'h8081_82F3);
    addr = 5'h10;
    @(negedge clk);
    rd_en = 1'b0;
    #1 chk("t6_v1", rvalid, 1);
    chk("t6_d1", rdata, 32'h2);
    @(negedge clk);
    #1 chk("t6_idle_v", rvalid, 0);
    chk("t6_idle_d", rdata, 32'h0);

    // Asynchronous reset during an outstanding load
    do_store(5'h18, 3'd2, 32'hF);
    addr = 5'h00; funct3 = 3'd2; rd_en = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("t1_rvalid", rvalid, 0);
    chk("t1_rdata", rdata, 0);
    chk("t1_irq", irq, 0);
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_load(5'h00, 3'd2, d); chk("t1_sw_after", d, 32'h0);
    do_load(5'h18, 3'd2, d); chk("t1_en_after", d, 32'h0);

    // Randomized traffic
    sw_base = sw;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rd_en = ($urandom % 3) == 0;
      wr_en = ($urandom % 4) == 0;
      case ($urandom % 5)
        0: addr = 5'h14;
        1: addr = 5'h18;
        2: addr = 5'h10;
        3: addr = 5'(4 * ($urandom % 2) + ($urandom % 4));
        default: addr = 5'($urandom);
      endcase
      funct3 = 3'($urandom);
      wdata = $urandom;
      if ($urandom % 60 == 0) sw_base = $urandom;
      sw = sw_base;
      if ($urandom % 30 == 0) sw = sw_base ^ (32'h1 << ($urandom % 32));
      if ($urandom % 20 == 0) btn = btn ^ NBTN'(1 << ($urandom % NBTN));
      if (c == 2000) rst = 1'b1;
      if (c == 2003) rst = 1'b0;
    end
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
